// File: rtl/bresenham_step_sequencer_if.sv
// Point-array input bundle and step/dir output bundle of the step sequencer.
interface bresenham_step_sequencer_if #(
    parameter int P_MAX_LINE_LENGTH = 10,
    parameter int P_X_COORD_W       = 11,
    parameter int P_Y_COORD_W       = 10
);
    logic [P_MAX_LINE_LENGTH*P_X_COORD_W-1:0] i_x_vals;
    logic [P_MAX_LINE_LENGTH*P_Y_COORD_W-1:0] i_y_vals;
    logic [P_MAX_LINE_LENGTH-1:0]             i_vals_valid;
    logic                                     i_vals_rdy;
    logic                                     o_x_step;
    logic                                     o_x_dir;
    logic                                     o_y_step;
    logic                                     o_y_dir;
    logic [P_X_COORD_W-1:0]                   o_pos_x;
    logic [P_Y_COORD_W-1:0]                   o_pos_y;
    logic                                     o_busy;
    logic                                     o_done;
    logic                                     o_err;
    logic                                     o_dropped;

    modport master (
        output i_x_vals, i_y_vals, i_vals_valid, i_vals_rdy,
        input  o_x_step, o_x_dir, o_y_step, o_y_dir, o_pos_x, o_pos_y,
               o_busy, o_done, o_err, o_dropped
    );

    modport slave (
        input  i_x_vals, i_y_vals, i_vals_valid, i_vals_rdy,
        output o_x_step, o_x_dir, o_y_step, o_y_dir, o_pos_x, o_pos_y,
               o_busy, o_done, o_err, o_dropped
    );
endinterface

// File: rtl/bresenham_step_sequencer.sv
// Walks a captured point list and emits one step/dir pulse per unit move between points.
// First step rises 4 cycles after the capture cycle; no backpressure, rdy while busy is dropped and flagged.
module bresenham_step_sequencer #(
    parameter int P_MAX_LINE_LENGTH    = 10,
    parameter int P_X_COORD_W          = 11,
    parameter int P_Y_COORD_W          = 10,
    parameter int P_PULSE_W_CYCLES     = 4,
    parameter int P_STEP_PERIOD_CYCLES = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    bresenham_step_sequencer_if.slave bus
);
    localparam int K_W        = $clog2(P_MAX_LINE_LENGTH + 1);
    localparam int CNT_W      = $clog2(P_STEP_PERIOD_CYCLES + 1);
    localparam int LOW_CYCLES = P_STEP_PERIOD_CYCLES - P_PULSE_W_CYCLES;
    localparam int XA_W       = P_MAX_LINE_LENGTH * P_X_COORD_W;
    localparam int YA_W       = P_MAX_LINE_LENGTH * P_Y_COORD_W;
    localparam logic [P_X_COORD_W:0] DX_ONE = (P_X_COORD_W + 1)'(1);
    localparam logic [P_Y_COORD_W:0] DY_ONE = (P_Y_COORD_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_EVAL, S_SETUP, S_HIGH, S_LOW, S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [XA_W-1:0]              x_arr_q, x_arr_d;
    logic [YA_W-1:0]              y_arr_q, y_arr_d;
    logic [P_MAX_LINE_LENGTH-1:0] valid_q, valid_d;
    logic [K_W-1:0]               k_q, k_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [P_X_COORD_W-1:0]       pos_x_q, pos_x_d;
    logic [P_Y_COORD_W-1:0]       pos_y_q, pos_y_d;
    logic                         x_dir_q, x_dir_d, y_dir_q, y_dir_d;
    logic [1:0]                   mask_q, mask_d;
    logic                         err_q, err_d, dropped_q, dropped_d;

    int                     kc, kp;
    logic [P_X_COORD_W-1:0] x_cur, x_prev;
    logic [P_Y_COORD_W-1:0] y_cur, y_prev;
    logic [P_X_COORD_W:0]   dx;
    logic [P_Y_COORD_W:0]   dy;
    logic                   x_act, y_act, x_unit, y_unit, k_end;

    // Index is clamped so the array select stays in range once k reaches the end.
    always_comb begin
        kc     = (int'(k_q) >= P_MAX_LINE_LENGTH) ? P_MAX_LINE_LENGTH - 1 : int'(k_q);
        kp     = (kc > 0) ? kc - 1 : 0;
        x_cur  = x_arr_q[kc*P_X_COORD_W +: P_X_COORD_W];
        x_prev = x_arr_q[kp*P_X_COORD_W +: P_X_COORD_W];
        y_cur  = y_arr_q[kc*P_Y_COORD_W +: P_Y_COORD_W];
        y_prev = y_arr_q[kp*P_Y_COORD_W +: P_Y_COORD_W];
        dx     = {1'b0, x_cur} - {1'b0, x_prev};
        dy     = {1'b0, y_cur} - {1'b0, y_prev};
        x_act  = (dx != '0);
        y_act  = (dy != '0);
        x_unit = !x_act || (dx == DX_ONE) || (dx == '1);
        y_unit = !y_act || (dy == DY_ONE) || (dy == '1);
        k_end  = (k_q >= K_W'(P_MAX_LINE_LENGTH));
    end

    always_comb begin
        state_d   = state_q;
        x_arr_d   = x_arr_q;
        y_arr_d   = y_arr_q;
        valid_d   = valid_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        x_dir_d   = x_dir_q;
        y_dir_d   = y_dir_q;
        mask_d    = mask_q;
        err_d     = err_q;
        dropped_d = bus.i_vals_rdy && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (bus.i_vals_rdy) begin
                    x_arr_d = bus.i_x_vals;
                    y_arr_d = bus.i_y_vals;
                    valid_d = bus.i_vals_valid;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!valid_q[0]) begin
                    state_d = S_DONE;
                end else begin
                    pos_x_d = x_arr_q[P_X_COORD_W-1:0];
                    pos_y_d = y_arr_q[P_Y_COORD_W-1:0];
                    k_d     = K_W'(1);
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (k_end || !valid_q[kc]) begin
                    state_d = S_DONE;
                end else if (!x_unit || !y_unit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (!x_act && !y_act) begin
                    k_d = k_q + K_W'(1);
                end else begin
                    mask_d = {y_act, x_act};
                    if (x_act) x_dir_d = (dx == DX_ONE);
                    if (y_act) y_dir_d = (dy == DY_ONE);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (mask_q[0]) pos_x_d = x_dir_q ? pos_x_q + P_X_COORD_W'(1) : pos_x_q - P_X_COORD_W'(1);
                if (mask_q[1]) pos_y_d = y_dir_q ? pos_y_q + P_Y_COORD_W'(1) : pos_y_q - P_Y_COORD_W'(1);
                cnt_d   = '0;
                state_d = S_HIGH;
            end
            S_HIGH: begin
                if (cnt_q == CNT_W'(P_PULSE_W_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOW: begin
                if (cnt_q == CNT_W'(LOW_CYCLES - 1)) begin
                    cnt_d   = '0;
                    k_d     = k_q + K_W'(1);
                    state_d = S_EVAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            x_arr_q   <= '0;
            y_arr_q   <= '0;
            valid_q   <= '0;
            k_q       <= '0;
            cnt_q     <= '0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            x_dir_q   <= 1'b0;
            y_dir_q   <= 1'b0;
            mask_q    <= '0;
            err_q     <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_arr_q   <= x_arr_d;
            y_arr_q   <= y_arr_d;
            valid_q   <= valid_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            x_dir_q   <= x_dir_d;
            y_dir_q   <= y_dir_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.o_x_step  = (state_q == S_HIGH) && mask_q[0];
    assign bus.o_y_step  = (state_q == S_HIGH) && mask_q[1];
    assign bus.o_x_dir   = x_dir_q;
    assign bus.o_y_dir   = y_dir_q;
    assign bus.o_pos_x   = pos_x_q;
    assign bus.o_pos_y   = pos_y_q;
    assign bus.o_busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.o_done    = (state_q == S_DONE);
    assign bus.o_err     = err_q;
    assign bus.o_dropped = dropped_q;
endmodule

// File: tb/tb_bresenham_step_sequencer.sv
// Table-driven bench with a pulse scoreboard for bresenham_step_sequencer.
module tb_bresenham_step_sequencer;
    localparam int N   = 10;
    localparam int XW  = 11;
    localparam int YW  = 10;
    localparam int PW  = 4;
    localparam int PER = 16;
    localparam int NV  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bresenham_step_sequencer_if #(.P_MAX_LINE_LENGTH(N), .P_X_COORD_W(XW), .P_Y_COORD_W(YW)) bus();

    bresenham_step_sequencer #(
        .P_MAX_LINE_LENGTH(N), .P_X_COORD_W(XW), .P_Y_COORD_W(YW),
        .P_PULSE_W_CYCLES(PW), .P_STEP_PERIOD_CYCLES(PER)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // Pulse code is {x_step, x_dir, y_step, y_dir}; dir bits only matter for stepping axes.
    typedef struct {
        int         t;
        logic [3:0] c;
    } ev_t;

    typedef struct {
        int           x[N];
        int           y[N];
        logic [N-1:0] valid;
        int           nev;
        int           ev_tm[N];
        logic [3:0]   ev_c[N];
        int           done_t;
        int           fx;
        int           fy;
        int           ferr;
    } vec_t;

    ev_t  sb[$];
    vec_t tv[NV];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   t_base = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (rel cycle %0d)", name, act, exp, cyc - t_base);
        end
    endtask

    logic       prev_hi = 1'b0;
    int         hi_len  = 0;
    logic       mon_hi;
    logic [3:0] mon_act, mon_msk;
    ev_t        mon_e;

    always @(negedge clk) begin
        mon_hi = bus.o_x_step | bus.o_y_step;
        if (!rst_n) begin
            prev_hi = 1'b0;
            hi_len  = 0;
        end else begin
            if (mon_hi && !prev_hi) begin
                mon_act = {bus.o_x_step, bus.o_x_dir, bus.o_y_step, bus.o_y_dir};
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got code %b at rel %0d, required no pulse", mon_act, cyc - t_base);
                end else begin
                    mon_e   = sb.pop_front();
                    mon_msk = {1'b1, mon_e.c[3], 1'b1, mon_e.c[1]};
                    check("pulse_time", cyc - t_base, mon_e.t);
                    check("pulse_code", int'(mon_act & mon_msk), int'(mon_e.c & mon_msk));
                end
                hi_len = 1;
            end else if (mon_hi) begin
                hi_len++;
            end else if (prev_hi) begin
                check("pulse_width", hi_len, PW);
            end
            prev_hi = mon_hi;
        end
    end

    task automatic set_vec(input int k, input logic [N-1:0] v, input int dt,
                           input int fx, input int fy, input int fe);
        tv[k].valid  = v;
        tv[k].done_t = dt;
        tv[k].fx     = fx;
        tv[k].fy     = fy;
        tv[k].ferr   = fe;
        tv[k].nev    = 0;
        for (int j = 0; j < N; j++) begin
            tv[k].x[j]     = 0;
            tv[k].y[j]     = 0;
            tv[k].ev_tm[j] = 0;
            tv[k].ev_c[j]  = 4'b0000;
        end
    endtask

    task automatic add_pt(input int k, input int j, input int x, input int y);
        tv[k].x[j] = x;
        tv[k].y[j] = y;
    endtask

    task automatic add_ev(input int k, input int t, input logic [3:0] c);
        tv[k].ev_tm[tv[k].nev] = t;
        tv[k].ev_c[tv[k].nev]  = c;
        tv[k].nev++;
    endtask

    task automatic start_case(input int i);
        ev_t e;
        @(negedge clk);
        for (int j = 0; j < N; j++) begin
            bus.i_x_vals[j*XW +: XW] = XW'(tv[i].x[j]);
            bus.i_y_vals[j*YW +: YW] = YW'(tv[i].y[j]);
        end
        bus.i_vals_valid = tv[i].valid;
        bus.i_vals_rdy   = 1'b1;
        t_base           = cyc;
        for (int j = 0; j < tv[i].nev; j++) begin
            e.t = tv[i].ev_tm[j];
            e.c = tv[i].ev_c[j];
            sb.push_back(e);
        end
    endtask

    task automatic scramble();
        for (int j = 0; j < N; j++) begin
            bus.i_x_vals[j*XW +: XW] = XW'($urandom);
            bus.i_y_vals[j*YW +: YW] = YW'($urandom);
        end
        bus.i_vals_valid = N'($urandom);
    endtask

    task automatic run_case(input int i, input int drop_at, input int dpx, input int dpy);
        int rel;
        bit seen;
        start_case(i);
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            rel = cyc - t_base;
            bus.i_vals_rdy = 1'b0;
            if (rel == 1) begin
                scramble();
                check("busy_after_capture", int'(bus.o_busy), 1);
            end
            if (drop_at > 0 && rel == drop_at) bus.i_vals_rdy = 1'b1;
            if (drop_at > 0 && rel == drop_at + 1) begin
                check("dropped_pulse", int'(bus.o_dropped), 1);
                check("drop_pos_x", int'(bus.o_pos_x), dpx);
                check("drop_pos_y", int'(bus.o_pos_y), dpy);
            end
            if (drop_at > 0 && rel == drop_at + 2) check("dropped_one_cycle", int'(bus.o_dropped), 0);
            if (bus.o_done) begin
                seen = 1'b1;
                check("done_time", rel, tv[i].done_t);
                check("final_pos_x", int'(bus.o_pos_x), tv[i].fx);
                check("final_pos_y", int'(bus.o_pos_y), tv[i].fy);
                check("final_err", int'(bus.o_err), tv[i].ferr);
                check("busy_in_done", int'(bus.o_busy), 0);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no o_done within 400 cycles of case %0d, required done at %0d", i, tv[i].done_t);
        end
        @(negedge clk);
        check("pulses_remaining", sb.size(), 0);
        check("done_one_cycle", int'(bus.o_done), 0);
        sb.delete();
    endtask

    initial begin
        bus.i_x_vals     = '0;
        bus.i_y_vals     = '0;
        bus.i_vals_valid = '0;
        bus.i_vals_rdy   = 1'b0;

        // 0: shallow ascending line
        set_vec(0, 10'h00F, 57, 3, 1, 0);
        add_pt(0, 0, 0, 0); add_pt(0, 1, 1, 0); add_pt(0, 2, 2, 1); add_pt(0, 3, 3, 1);
        add_ev(0, 4, 4'b1100); add_ev(0, 22, 4'b1111); add_ev(0, 40, 4'b1100);
        // 1: steep descending line
        set_vec(1, 10'h007, 39, 6, 7, 0);
        add_pt(1, 0, 5, 9); add_pt(1, 1, 5, 8); add_pt(1, 2, 6, 7);
        add_ev(1, 4, 4'b0010); add_ev(1, 22, 4'b1110);
        // 2: duplicate point costs one EVAL cycle only
        set_vec(2, 10'h007, 22, 3, 2, 0);
        add_pt(2, 0, 2, 2); add_pt(2, 1, 2, 2); add_pt(2, 2, 3, 2);
        add_ev(2, 5, 4'b1100);
        // 3: non-unit jump
        set_vec(3, 10'h003, 3, 0, 0, 1);
        add_pt(3, 0, 0, 0); add_pt(3, 1, 3, 0);
        // 4: top-of-range coordinates, diagonal down
        set_vec(4, 10'h003, 21, 2046, 1022, 0);
        add_pt(4, 0, 2047, 1023); add_pt(4, 1, 2046, 1022);
        add_ev(4, 4, 4'b1010);
        // 5: full-range jump must not alias to a unit move
        set_vec(5, 10'h003, 3, 0, 0, 1);
        add_pt(5, 0, 0, 0); add_pt(5, 1, 2047, 0);
        // 6: no valid points
        set_vec(6, 10'h000, 2, 0, 0, 0);
        add_pt(6, 0, 7, 7);
        // 7: all slots valid, diagonal
        set_vec(7, 10'h3FF, 165, 9, 9, 0);
        for (int j = 0; j < N; j++) add_pt(7, j, j, j);
        for (int j = 0; j < N - 1; j++) add_ev(7, 4 + 18 * j, 4'b1111);

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x_step",  int'(bus.o_x_step), 0);
        check("rst_y_step",  int'(bus.o_y_step), 0);
        check("rst_x_dir",   int'(bus.o_x_dir), 0);
        check("rst_y_dir",   int'(bus.o_y_dir), 0);
        check("rst_pos_x",   int'(bus.o_pos_x), 0);
        check("rst_pos_y",   int'(bus.o_pos_y), 0);
        check("rst_busy",    int'(bus.o_busy), 0);
        check("rst_done",    int'(bus.o_done), 0);
        check("rst_err",     int'(bus.o_err), 0);
        check("rst_dropped", int'(bus.o_dropped), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) run_case(i, 0, 0, 0);

        // rdy during the first HIGH phase of case 0 is dropped
        run_case(0, 5, 1, 0);

        // reset in the middle of a step pulse
        start_case(0);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            bus.i_vals_rdy = 1'b0;
        end
        check("step_before_rst", int'(bus.o_x_step), 1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_x_step", int'(bus.o_x_step), 0);
        check("rst_mid_busy",   int'(bus.o_busy), 0);
        check("rst_mid_pos_x",  int'(bus.o_pos_x), 0);
        check("rst_mid_pos_y",  int'(bus.o_pos_y), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_resume_busy", int'(bus.o_busy), 0);
        check("no_resume_step", int'(bus.o_x_step | bus.o_y_step), 0);
        run_case(1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
